// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM transmit path.
package pdm_pkg;

  localparam int unsigned PCMBIT        = 16;
  localparam int unsigned PDM_SCLK_HZ   = 2_000_000;
  localparam int unsigned OSR_DEFAULT   = 125;
  localparam int unsigned DEPTH_DEFAULT = 16;

  // Signed two's complement to offset binary (flip the sign bit).
  function automatic logic [PCMBIT-1:0] to_offset_bin(input logic [PCMBIT-1:0] s);
    return {~s[PCMBIT-1], s[PCMBIT-2:0]};
  endfunction

endpackage

// File: rtl/pdm_tx_fifo.sv
// DEPTH x PCMBIT synchronous sample FIFO with registered full/empty and sticky overflow.
module pdm_tx_fifo
  import pdm_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [PCMBIT-1:0] wdata,
  input  logic              rd,
  output logic [PCMBIT-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PCMBIT-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next_c;
  logic              wr_en_c;
  logic              rd_en_c;

  assign wr_en_c = wr & ~full;
  assign rd_en_c = rd & ~empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this clock's accepted write and/or read.
  always_comb begin
    count_next_c = count;
    case ({wr_en_c, rd_en_c})
      2'b10:   count_next_c = count + (AW+1)'(1);
      2'b01:   count_next_c = count - (AW+1)'(1);
      default: count_next_c = count;
    endcase
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en_c) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next_c;
      full     <= (count_next_c == (AW+1)'(DEPTH));
      empty    <= (count_next_c == '0);
      overflow <= overflow | (wr & full);
    end
  end

endmodule

// File: rtl/pdm_mic_tx.sv
// PCM-to-PDM transmitter: sample FIFO feeding a first-order sigma-delta modulator clocked by sclk ticks.
module pdm_mic_tx
  import pdm_pkg::*;
#(
  parameter int unsigned OSR   = OSR_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              en,
  input  logic [PCMBIT-1:0] pcm_i,
  input  logic              wr,
  output logic              full,
  output logic              empty,
  output logic              dat_o,
  output logic              underrun,
  output logic              overflow
);

  localparam int unsigned OW = $clog2(OSR);

  logic              sclk_d;
  logic [OW-1:0]     osr_cnt;
  logic [PCMBIT-1:0] cur;
  logic [PCMBIT-1:0] acc;
  logic [PCMBIT-1:0] fifo_rdata;
  logic              tick_c;
  logic              fetch_c;
  logic              rd_c;
  logic [PCMBIT-1:0] cur_src_c;
  logic [PCMBIT-1:0] u_c;
  logic [PCMBIT:0]   sum_c;

  pdm_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .wdata    (pcm_i),
    .rd       (rd_c),
    .rdata    (fifo_rdata),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // Tick and fetch decode; a freshly fetched sample bypasses cur into the modulator.
  assign tick_c    = sclk & ~sclk_d;
  assign fetch_c   = tick_c & en & (osr_cnt == '0);
  assign rd_c      = fetch_c & ~empty;
  assign cur_src_c = rd_c ? fifo_rdata : cur;
  assign u_c       = to_offset_bin(cur_src_c);
  assign sum_c     = {1'b0, acc} + {1'b0, u_c};

  // sclk edge detect, frame counter, sample hold and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d   <= 1'b0;
      osr_cnt  <= '0;
      cur      <= '0;
      acc      <= '0;
      dat_o    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sclk_d   <= sclk;
      underrun <= fetch_c & empty;
      if (!en) begin
        osr_cnt <= '0;
        cur     <= '0;
        acc     <= '0;
        dat_o   <= 1'b0;
      end else if (tick_c) begin
        cur     <= cur_src_c;
        acc     <= sum_c[PCMBIT-1:0];
        dat_o   <= sum_c[PCMBIT];
        osr_cnt <= (osr_cnt == OW'(OSR - 1)) ? '0 : osr_cnt + OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_tx.sv
// Scoreboard bench for pdm_mic_tx: driver models expected PDM bits per tick, monitor compares.
module tb_pdm_mic_tx;

  localparam int OSR   = 125;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pcm_i = '0;
  logic        wr = 1'b0;
  logic        full, empty, dat_o, underrun, overflow;

  pdm_mic_tx dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .en       (en),
    .pcm_i    (pcm_i),
    .wr       (wr),
    .full     (full),
    .empty    (empty),
    .dat_o    (dat_o),
    .underrun (underrun),
    .overflow (overflow)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: sample queue, held sample, accumulator, frame position.
  logic [15:0]        mq[$];
  logic signed [15:0] cur_m = '0;
  int                 acc_m = 0;
  int                 osr_m = 0;
  bit                 ovf_m = 0;
  bit                 sprev_m = 0;
  bit                 en_r = 0;
  bit [1:0]           exp_q[$];   // {dat_o, underrun} per tick

  bit mon_on = 0;
  int ones_cnt = 0;
  int und_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of one clk, given the inputs applied on it.
  task automatic model(input bit s, input bit e, input bit w, input logic [15:0] d);
    bit tk, wr_ok, dat, und;
    int pre, u;
    tk = s & ~sprev_m;
    sprev_m = s;
    pre = mq.size();
    wr_ok = w && (pre < DEPTH);
    if (w && !wr_ok) ovf_m = 1;
    if (!e) begin
      cur_m = '0; acc_m = 0; osr_m = 0;
      if (tk) exp_q.push_back(2'b00);
    end else if (tk) begin
      und = 0;
      if (osr_m == 0) begin
        if (pre > 0) cur_m = mq.pop_front();
        else und = 1;
      end
      u = int'(cur_m) + 32768;
      acc_m = acc_m + u;
      dat = (acc_m >= 65536);
      if (dat) acc_m = acc_m - 65536;
      osr_m = (osr_m + 1) % OSR;
      exp_q.push_back({dat, und});
    end
    if (wr_ok) mq.push_back(d);
  endtask

  // Apply inputs for one clk (entered and left at posedge+1), update model, check FIFO flags.
  task automatic step(input bit s, input bit w, input logic [15:0] d);
    sclk = s; wr = w; pcm_i = d; en = en_r;
    @(posedge clk);
    model(s, en_r, w, d);
    #1;
    wr = 1'b0;
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic run_ticks(input int n, input int wprob, input int enflip);
    bit w;
    for (int i = 0; i < n; i++) begin
      if (enflip > 0 && $urandom_range(99) < enflip) en_r = ~en_r;
      step(1, 0, '0);
      step(1, 0, '0);
      w = ($urandom_range(99) < wprob);
      step(0, w, 16'($urandom));
      step(0, 0, '0);
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #3;
    reset = 1'b1;
    sclk = 1'b0;
    en_r = 0;
    en = 1'b0;
    #1;
    chk({tag, "_dat_o"}, 32'(dat_o), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_underrun"}, 32'(underrun), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    mq.delete();
    cur_m = '0; acc_m = 0; osr_m = 0; ovf_m = 0; sprev_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: detects ticks from sclk independently and pops the scoreboard on each.
  initial begin
    bit mprev, t;
    bit [1:0] e;
    mprev = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mprev = 0; t = 0;
      end else begin
        t = sclk & ~mprev;
        mprev = sclk;
      end
      @(negedge clk);
      if (mon_on && !reset) begin
        if (t) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("dat_o", 32'(dat_o), 32'(e[1]));
            chk("underrun", 32'(underrun), 32'(e[0]));
          end
          if (dat_o === 1'b1) ones_cnt++;
          if (underrun === 1'b1) und_cnt++;
        end else begin
          chk("underrun_idle", 32'(underrun), 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_o, base_u, ones, s, u;
    real err;
    logic [15:0] sine[$];

    @(posedge clk);
    #1;
    do_reset("rst0");
    mon_on = 1;

    // Zero sample: alternating bits, one underrun when the second frame is due.
    step(0, 1, 16'h0000);
    step(0, 0, '0);
    en_r = 1;
    base_o = ones_cnt; base_u = und_cnt;
    run_ticks(OSR, 0, 0);
    chk("zero_ones_frame", 32'(ones_cnt - base_o), 62);
    chk("zero_no_underrun", 32'(und_cnt - base_u), 0);
    run_ticks(OSR, 0, 0);
    chk("underrun_once", 32'(und_cnt - base_u), 1);

    // Full-scale negative then positive.
    do_reset("rst1");
    step(0, 1, 16'h8000);
    step(0, 1, 16'h7FFF);
    en_r = 1;
    base_o = ones_cnt;
    run_ticks(OSR, 0, 0);
    chk("neg_fs_ones", 32'(ones_cnt - base_o), 0);
    base_o = ones_cnt;
    run_ticks(OSR, 0, 0);
    chk("pos_fs_ones", 32'(ones_cnt - base_o), 124);
    run_ticks(10, 0, 0);

    // Fill past capacity while disabled, then run part of a frame.
    do_reset("rst2");
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(0, 1, 16'($urandom));
      if (i == DEPTH - 1) chk("full_at_16", 32'(full), 1);
    end
    chk("overflow_at_17", 32'(overflow), 1);
    chk("still_full", 32'(full), 1);
    en_r = 1;
    run_ticks(60, 5, 0);
    chk("overflow_sticky", 32'(overflow), 1);
    do_reset("rst_mid");
    run_ticks(5, 0, 0);

    // 1 kHz sine at 16 kHz sample rate; per-frame ones count tracks the sample.
    for (int k = 0; k < 24; k++) begin
      s = $rtoi(20000.0 * $sin(2.0 * 3.14159265358979 * k / 16.0));
      sine.push_back(16'(s));
    end
    for (int k = 0; k < 4; k++) step(0, 1, sine[k]);
    en_r = 1;
    for (int f = 0; f < 20; f++) begin
      base_o = ones_cnt;
      step(1, 0, '0);
      step(1, 0, '0);
      step(0, 1, sine[f + 4]);
      step(0, 0, '0);
      run_ticks(OSR - 1, 0, 0);
      ones = ones_cnt - base_o;
      u = int'($signed(sine[f])) + 32768;
      err = real'(ones) - real'(u) * real'(OSR) / 65536.0;
      n_checks++;
      if (err > 1.0 || err < -1.0) begin
        n_fail++;
        $display("FAIL sine_density frame %0d: got %0d ones expected about %0f", f, ones, real'(u) * real'(OSR) / 65536.0);
      end
    end

    // Random data, random enable toggles, sparse writes.
    do_reset("rst3");
    for (int k = 0; k < 6; k++) step(0, 1, 16'($urandom));
    en_r = 1;
    run_ticks(1500, 1, 1);
    en_r = 0;
    run_ticks(3, 0, 0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
